cmd_packer: RTL and testbench
=============================

# cmd_packer

Command-side transmitter for the CMD FIFO. Accepts one parsed layer descriptor per handshake, validates it, serializes it into the three 32-bit words the command sequencer decodes, and writes them into the CMD FIFO under `full` back-pressure. It keeps the running command count that drives the sequencer's `cmd_size`, and raises `op_en` once the loaded program is sealed.

## Interface
Parameters:
- `CMD_BURST_LEN`, 3: words per command.
- `MAX_CMDS`, 127: capacity, limited by the 7-bit `cmd_size`.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `desc_valid` in 1: descriptor present.
- `desc_ready` out 1: descriptor accepted when both `desc_valid` and `desc_ready` are 1.
- `op_type` in 3: operation type. Legal values: 001 conv+ReLU, 100 max pool, 101 avg pool.
- `stride` in 4.
- `kernel` in 8.
- `i_side` in 8.
- `o_side` in 8.
- `i_channel` in 16.
- `o_channel` in 16.
- `kernel_size` in 8.
- `stride2` in 16.
- `go` in 1: seal the program and start the engine.
- `full` in 1: CMD FIFO full.
- `wr_en` out 1: FIFO write strobe.
- `din` out 32: FIFO write data.
- `cmd_size` out 7: number of commands written.
- `op_en` out 1: start level to the sequencer. Sticky until `rst`.
- `err_illegal` out 1: sticky. A descriptor was rejected.
- `err_overflow` out 1: sticky. A descriptor arrived while `cmd_size == MAX_CMDS`.

## Operation
Word layout:
- W0: `{o_side, i_side, kernel, stride, 1'b0, op_type}`
- W1: `{o_channel, i_channel}`
- W2: `{stride2, kernel_size, 8'h00}`

State machine (IDLE, W0, W1, W2, STARTED):
- IDLE:
  - `desc_ready = 1`.
  - On handshake, latch all fields and check the descriptor.
  - Valid descriptor: go to W0.
  - Illegal `op_type`, `stride == 0`, `kernel == 0`, or `stride > kernel`: set `err_illegal`, stay in IDLE, write nothing.
  - `cmd_size == MAX_CMDS`: set `err_overflow`, drop the descriptor, stay in IDLE.
  - If the handshake does not occur and `go == 1` with `cmd_size != 0`: go to STARTED.
- W0, W1, W2:
  - `desc_ready = 0`.
  - `wr_en = !full`, combinational. `din` is the word for the current state.
  - On a write (`wr_en == 1`), advance W0→W1→W2.
  - The write in W2 increments `cmd_size` and returns to IDLE.
  - `go` is ignored in these states.
- STARTED:
  - `op_en = 1`, `desc_ready = 0`.
  - Terminal until `rst`.
- `din` is 0 whenever `wr_en == 0`.

## Timing
- Reset values: `desc_ready` 0 in the reset cycle, then 1 in IDLE. `wr_en` 0, `din` 0, `cmd_size` 0, `op_en` 0, `err_illegal` 0, `err_overflow` 0.
- Latency: handshake in cycle N → first `wr_en` in N+1 if `full == 0`.
- Throughput: 4 cycles per command with no back-pressure (one IDLE cycle plus three words).
- `full` high stalls the current word with no loss and no duplicate. Words are never reordered.
- `full` toggling between words: each word is written exactly once.
- `go` and `desc_valid` in the same IDLE cycle: the descriptor wins and `go` is ignored. `go` must be held to take effect.
- `go` with `cmd_size == 0`: ignored.
- `op_en` rises the cycle after `go` is sampled in IDLE.
- `rst` mid-burst: immediate return to IDLE with counters cleared. The CMD FIFO must be reset in the same cycle, because partially written words are not recovered.
- `cmd_size` never wraps. It saturates at 127 via the overflow rule.

## Structure
- In the shared `macros.vh`:
  - `CMD_BURST_LEN`.
  - op_type codes: `OP_IDLE` 000, `OP_CONV` 001, `OP_MPOOL` 100, `OP_APOOL` 101.
  - State encodings.
  - W0/W1/W2 field bit positions.
- The decoder side uses the same layout constants, so the packer and the sequencer cannot drift.
- One sub-module: `cmd_check`, combinational descriptor validation producing `legal` and a reason.
- Packing stays inline.

## Test plan
- Descriptor op 1, stride 2, kernel 3, i_side 227, o_side 113, i_ch 3, o_ch 64, ksize 9, stride2 6 → `din` 0x71E30321, 0x00400003, 0x00060900 on three consecutive `wr_en` cycles; `cmd_size` = 1.
- Same descriptor with `full` high for 5 cycles during W1 → W1 is written exactly once after `full` drops; total 3 writes; output identical.
- op_type 010, or stride 4 with kernel 3 → no `wr_en`, `err_illegal` = 1, `cmd_size` unchanged. The next legal descriptor is still written.
- 127 legal descriptors, then a 128th → 381 writes, `cmd_size` = 127, `err_overflow` = 1, no 382nd write.
- `go` together with `desc_valid` → descriptor written. `go` held afterwards → `op_en` = 1 and `desc_ready` = 0 from then on. `go` with `cmd_size` = 0 → `op_en` stays 0.
- `rst` asserted in W1 → next cycle: IDLE, `wr_en` 0, `cmd_size` 0, `op_en` 0, both error flags cleared.

Source files
------------

// File: rtl/cmd_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmd_packer_pkg                                         |
// | Description : Shared command-word layout, op codes, FSM states and   |
// |               descriptor-check reasons for the CMD FIFO packer and   |
// |               the command sequencer that decodes the same words.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cmd_packer_pkg;

  // Words per command and command capacity (bounded by the 7-bit count).
  localparam int CMD_BURST_LEN = 3;
  localparam int MAX_CMDS      = 127;
  localparam int CMD_SIZE_W    = 7;

  // Operation codes carried in W0.
  localparam logic [2:0] OP_IDLE  = 3'b000;
  localparam logic [2:0] OP_CONV  = 3'b001;
  localparam logic [2:0] OP_MPOOL = 3'b100;
  localparam logic [2:0] OP_APOOL = 3'b101;

  // Burst states are contiguous so the word index is (state - ST_W0).
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W0      = 3'd1,
    ST_W1      = 3'd2,
    ST_W2      = 3'd3,
    ST_STARTED = 3'd4
  } state_t;

  // Why a descriptor was refused (first failing rule wins).
  typedef enum logic [2:0] {
    CHK_OK               = 3'd0,
    CHK_BAD_OP           = 3'd1,
    CHK_ZERO_STRIDE      = 3'd2,
    CHK_ZERO_KERNEL      = 3'd3,
    CHK_STRIDE_GT_KERNEL = 3'd4
  } chk_reason_t;

  // W0 field positions; bit 3 is reserved and always zero.
  localparam int W0_OP_LSB     = 0;
  localparam int W0_STRIDE_LSB = 4;
  localparam int W0_KERNEL_LSB = 8;
  localparam int W0_ISIDE_LSB  = 16;
  localparam int W0_OSIDE_LSB  = 24;

  // W1 field positions.
  localparam int W1_ICH_LSB = 0;
  localparam int W1_OCH_LSB = 16;

  // W2 field positions; the low byte is reserved and always zero.
  localparam int W2_KSIZE_LSB   = 8;
  localparam int W2_STRIDE2_LSB = 16;

  // One parsed layer descriptor.
  typedef struct packed {
    logic [2:0]  op_type;
    logic [3:0]  stride;
    logic [7:0]  kernel;
    logic [7:0]  i_side;
    logic [7:0]  o_side;
    logic [15:0] i_channel;
    logic [15:0] o_channel;
    logic [7:0]  kernel_size;
    logic [15:0] stride2;
  } desc_t;

  function automatic logic [31:0] pack_w0(input desc_t d);
    logic [31:0] w;
    w = '0;
    w[W0_OP_LSB     +: 3] = d.op_type;
    w[W0_STRIDE_LSB +: 4] = d.stride;
    w[W0_KERNEL_LSB +: 8] = d.kernel;
    w[W0_ISIDE_LSB  +: 8] = d.i_side;
    w[W0_OSIDE_LSB  +: 8] = d.o_side;
    return w;
  endfunction

  function automatic logic [31:0] pack_w1(input desc_t d);
    logic [31:0] w;
    w = '0;
    w[W1_ICH_LSB +: 16] = d.i_channel;
    w[W1_OCH_LSB +: 16] = d.o_channel;
    return w;
  endfunction

  function automatic logic [31:0] pack_w2(input desc_t d);
    logic [31:0] w;
    w = '0;
    w[W2_KSIZE_LSB   +: 8]  = d.kernel_size;
    w[W2_STRIDE2_LSB +: 16] = d.stride2;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmd_packer_if                                          |
// | Description : Descriptor handshake, CMD FIFO write port and status   |
// |               signals of the command packer.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface cmd_packer_if;

  logic        desc_valid;
  logic        desc_ready;
  logic [2:0]  op_type;
  logic [3:0]  stride;
  logic [7:0]  kernel;
  logic [7:0]  i_side;
  logic [7:0]  o_side;
  logic [15:0] i_channel;
  logic [15:0] o_channel;
  logic [7:0]  kernel_size;
  logic [15:0] stride2;
  logic        go;
  logic        full;
  logic        wr_en;
  logic [31:0] din;
  logic [6:0]  cmd_size;
  logic        op_en;
  logic        err_illegal;
  logic        err_overflow;

  // Descriptor source / FIFO / sequencer side.
  modport master (
    output desc_valid, op_type, stride, kernel, i_side, o_side,
           i_channel, o_channel, kernel_size, stride2, go, full,
    input  desc_ready, wr_en, din, cmd_size, op_en, err_illegal, err_overflow
  );

  // Packer side.
  modport slave (
    input  desc_valid, op_type, stride, kernel, i_side, o_side,
           i_channel, o_channel, kernel_size, stride2, go, full,
    output desc_ready, wr_en, din, cmd_size, op_en, err_illegal, err_overflow
  );

endinterface
`default_nettype wire

// File: rtl/cmd_packer_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmd_check                                              |
// | Description : Combinational descriptor validation: legal op code,    |
// |               non-zero stride and kernel, stride not above kernel.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cmd_check
  import cmd_packer_pkg::*;
(
  input  logic [2:0]  op_type,
  input  logic [3:0]  stride,
  input  logic [7:0]  kernel,
  output logic        legal,
  output chk_reason_t reason
);

  // First failing rule determines the reported reason.
  always_comb begin
    reason = CHK_OK;
    if (!((op_type == OP_CONV) || (op_type == OP_MPOOL) || (op_type == OP_APOOL))) begin
      reason = CHK_BAD_OP;
    end else if (stride == 4'd0) begin
      reason = CHK_ZERO_STRIDE;
    end else if (kernel == 8'd0) begin
      reason = CHK_ZERO_KERNEL;
    end else if ({4'd0, stride} > kernel) begin
      reason = CHK_STRIDE_GT_KERNEL;
    end
    legal = (reason == CHK_OK);
  end

endmodule
`default_nettype wire

// File: rtl/cmd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmd_packer                                             |
// | Description : Accepts layer descriptors, validates them, serializes  |
// |               each into three 32-bit command words for the CMD FIFO  |
// |               under full back-pressure, counts commands and raises   |
// |               op_en once the program is sealed with go.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cmd_packer #(
  parameter int CMD_BURST_LEN = cmd_packer_pkg::CMD_BURST_LEN,
  parameter int MAX_CMDS      = cmd_packer_pkg::MAX_CMDS
) (
  input  logic         clk,
  input  logic         rst,
  cmd_packer_if.slave  bus
);

  import cmd_packer_pkg::*;

  localparam logic [CMD_SIZE_W-1:0] c_max_cmds  = CMD_SIZE_W'(MAX_CMDS);
  localparam logic [1:0]            c_last_word = 2'(CMD_BURST_LEN - 1);

  state_t                r_state;
  logic                  r_ready;
  logic [CMD_SIZE_W-1:0] r_cmd_size;
  logic                  r_op_en;
  logic                  r_err_illegal;
  logic                  r_err_overflow;
  desc_t                 r_desc;

  desc_t                 w_desc_in;
  logic                  w_legal;
  chk_reason_t           w_reason;
  logic                  w_desc_ok;
  logic                  w_handshake;
  logic                  w_at_capacity;
  logic                  w_in_burst;
  logic                  w_wr_en;
  logic [1:0]            w_word_idx;
  logic                  w_last_word;
  logic [31:0]           w_word;

  assign w_desc_in = '{
    op_type:     bus.op_type,
    stride:      bus.stride,
    kernel:      bus.kernel,
    i_side:      bus.i_side,
    o_side:      bus.o_side,
    i_channel:   bus.i_channel,
    o_channel:   bus.o_channel,
    kernel_size: bus.kernel_size,
    stride2:     bus.stride2
  };

  cmd_check u_check (
    .op_type (bus.op_type),
    .stride  (bus.stride),
    .kernel  (bus.kernel),
    .legal   (w_legal),
    .reason  (w_reason)
  );

  // Accept only when both views of the checker's verdict agree on "clean".
  assign w_desc_ok     = w_legal && (w_reason == CHK_OK);
  // desc_ready is held low for the whole cycle in which rst is asserted.
  assign w_handshake   = bus.desc_valid && r_ready && !rst;
  assign w_at_capacity = (r_cmd_size == c_max_cmds);

  assign w_in_burst  = (r_state == ST_W0) || (r_state == ST_W1) || (r_state == ST_W2);
  assign w_wr_en     = w_in_burst && !bus.full;
  assign w_word_idx  = 2'(r_state - ST_W0);
  assign w_last_word = (w_word_idx == c_last_word);

  // Select the word for the current burst state.
  always_comb begin
    w_word = '0;
    case (r_state)
      ST_W0:   w_word = pack_w0(r_desc);
      ST_W1:   w_word = pack_w1(r_desc);
      ST_W2:   w_word = pack_w2(r_desc);
      default: w_word = '0;
    endcase
  end

  // Control FSM: descriptor intake, three-word burst, sealed terminal state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_ready        <= 1'b1;
      r_cmd_size     <= '0;
      r_op_en        <= 1'b0;
      r_err_illegal  <= 1'b0;
      r_err_overflow <= 1'b0;
      r_desc         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_desc <= w_desc_in;
            // A full program drops everything, regardless of legality.
            if (w_at_capacity) begin
              r_err_overflow <= 1'b1;
            end else if (!w_desc_ok) begin
              r_err_illegal <= 1'b1;
            end else begin
              r_state <= ST_W0;
              r_ready <= 1'b0;
            end
          end else if (bus.go && (r_cmd_size != '0)) begin
            r_state <= ST_STARTED;
            r_ready <= 1'b0;
            r_op_en <= 1'b1;
          end
        end

        ST_W0, ST_W1, ST_W2: begin
          // Advance only on an actual FIFO write so a stalled word is reissued.
          if (w_wr_en) begin
            if (w_last_word) begin
              r_state    <= ST_IDLE;
              r_ready    <= 1'b1;
              r_cmd_size <= r_cmd_size + CMD_SIZE_W'(1);
            end else begin
              r_state <= state_t'(r_state + 3'd1);
            end
          end
        end

        ST_STARTED: begin
          r_state <= ST_STARTED;
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.desc_ready   = r_ready && !rst;
  assign bus.wr_en        = w_wr_en;
  assign bus.din          = w_wr_en ? w_word : 32'd0;
  assign bus.cmd_size     = r_cmd_size;
  assign bus.op_en        = r_op_en;
  assign bus.err_illegal  = r_err_illegal;
  assign bus.err_overflow = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cmd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cmd_packer                                          |
// | Description : Self-checking bench for cmd_packer: descriptor table   |
// |               plus back-pressure, reset, overflow and go sequences.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_cmd_packer;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  stride;
    logic [7:0]  kernel;
    logic [7:0]  i_side;
    logic [7:0]  o_side;
    logic [15:0] ich;
    logic [15:0] och;
    logic [7:0]  ksize;
    logic [15:0] stride2;
    bit          legal;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   wr_total;
  int   model_size;
  bit   seen_illegal;
  logic [31:0] wq[$];
  vec_t vecs[10];

  cmd_packer_if bus();

  cmd_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] s, input logic [7:0] k,
                              input logic [7:0] is, input logic [7:0] os,
                              input logic [15:0] ic, input logic [15:0] oc,
                              input logic [7:0] ks, input logic [15:0] s2, input bit lg,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    vec_t v;
    v.op = op; v.stride = s; v.kernel = k; v.i_side = is; v.o_side = os;
    v.ich = ic; v.och = oc; v.ksize = ks; v.stride2 = s2; v.legal = lg;
    v.w0 = a; v.w1 = b; v.w2 = c;
    return v;
  endfunction

  // Capture every FIFO write; din must be zero on non-write cycles.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wq.push_back(bus.din);
      wr_total++;
    end else if (rst === 1'b0) begin
      chk("din_idle_zero", bus.din, 32'd0);
    end
  end

  // Present a descriptor and complete one handshake (bounded wait).
  task automatic send_desc(input vec_t v, input bit with_go);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.op_type = v.op; bus.stride = v.stride; bus.kernel = v.kernel;
    bus.i_side = v.i_side; bus.o_side = v.o_side;
    bus.i_channel = v.ich; bus.o_channel = v.och;
    bus.kernel_size = v.ksize; bus.stride2 = v.stride2;
    bus.desc_valid = 1'b1;
    bus.go = with_go;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.desc_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.desc_valid = 1'b0;
    if (!ok) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  // Wait (bounded) until the packer is back in IDLE with no write pending.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.desc_ready === 1'b1 && bus.wr_en === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_words(input string tag, input vec_t v);
    chk({tag, "_nwords"}, wq.size(), 32'd3);
    if (wq.size() == 3) begin
      chk({tag, "_w0"}, wq[0], v.w0);
      chk({tag, "_w1"}, wq[1], v.w1);
      chk({tag, "_w2"}, wq[2], v.w2);
    end
    wq.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_fail = 0; wr_total = 0; model_size = 0; seen_illegal = 1'b0;
    rst = 1'b1;
    bus.desc_valid = 1'b0; bus.go = 1'b0; bus.full = 1'b0;
    bus.op_type = '0; bus.stride = '0; bus.kernel = '0; bus.i_side = '0; bus.o_side = '0;
    bus.i_channel = '0; bus.o_channel = '0; bus.kernel_size = '0; bus.stride2 = '0;

    //            op      s      k      is     os     ich       och       ks     s2       lg    w0            w1            w2
    vecs[0] = mk(3'b001, 4'd2,  8'd3,  8'd227, 8'd113, 16'd3,   16'd64,   8'd9,  16'd6,   1'b1, 32'h71E30321, 32'h00400003, 32'h00060900);
    vecs[1] = mk(3'b100, 4'd2,  8'd2,  8'h38,  8'h1C,  16'h40,  16'h40,   8'd4,  16'd2,   1'b1, 32'h1C380224, 32'h00400040, 32'h00020400);
    vecs[2] = mk(3'b101, 4'd1,  8'd7,  8'd7,   8'd1,   16'h200, 16'h200,  8'h31, 16'd1,   1'b1, 32'h01070715, 32'h02000200, 32'h00013100);
    vecs[3] = mk(3'b010, 4'd1,  8'd3,  8'd9,   8'd9,   16'd1,   16'd1,    8'd1,  16'd1,   1'b0, 32'h0, 32'h0, 32'h0);
    vecs[4] = mk(3'b001, 4'd4,  8'd3,  8'd9,   8'd9,   16'd1,   16'd1,    8'd1,  16'd1,   1'b0, 32'h0, 32'h0, 32'h0);
    vecs[5] = mk(3'b001, 4'd0,  8'd3,  8'd9,   8'd9,   16'd1,   16'd1,    8'd1,  16'd1,   1'b0, 32'h0, 32'h0, 32'h0);
    vecs[6] = mk(3'b001, 4'd1,  8'd0,  8'd9,   8'd9,   16'd1,   16'd1,    8'd1,  16'd1,   1'b0, 32'h0, 32'h0, 32'h0);
    vecs[7] = mk(3'b000, 4'd1,  8'd3,  8'd9,   8'd9,   16'd1,   16'd1,    8'd1,  16'd1,   1'b0, 32'h0, 32'h0, 32'h0);
    vecs[8] = mk(3'b001, 4'd15, 8'hFF, 8'hFF,  8'hFF,  16'hFFFF,16'hFFFF, 8'hFF, 16'hFFFF,1'b1, 32'hFFFFFFF1, 32'hFFFFFFFF, 32'hFFFFFF00);
    vecs[9] = mk(3'b001, 4'd3,  8'd3,  8'd0,   8'd0,   16'd0,   16'd0,    8'd0,  16'd0,   1'b1, 32'h00000331, 32'h00000000, 32'h00000000);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_desc_ready", bus.desc_ready, 32'd0);
    chk("rst_wr_en", bus.wr_en, 32'd0);
    chk("rst_din", bus.din, 32'd0);
    chk("rst_cmd_size", bus.cmd_size, 32'd0);
    chk("rst_op_en", bus.op_en, 32'd0);
    chk("rst_err_illegal", bus.err_illegal, 32'd0);
    chk("rst_err_overflow", bus.err_overflow, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_desc_ready", bus.desc_ready, 32'd1);

    // go with an empty program is ignored.
    @(posedge clk); #1;
    bus.go = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("go_empty_op_en", bus.op_en, 32'd0);
    end
    chk("go_empty_ready", bus.desc_ready, 32'd1);
    @(posedge clk); #1;
    bus.go = 1'b0;

    // Descriptor table.
    for (int i = 0; i < 10; i++) begin
      send_desc(vecs[i], 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_first_wr_en", i), bus.wr_en, {31'd0, vecs[i].legal});
      wait_idle();
      if (vecs[i].legal) begin
        model_size++;
        check_words($sformatf("v%0d", i), vecs[i]);
      end else begin
        seen_illegal = 1'b1;
        chk($sformatf("v%0d_nwords", i), wq.size(), 32'd0);
        wq.delete();
      end
      chk($sformatf("v%0d_cmd_size", i), bus.cmd_size, model_size);
      chk($sformatf("v%0d_err_illegal", i), bus.err_illegal, {31'd0, seen_illegal});
      chk($sformatf("v%0d_err_overflow", i), bus.err_overflow, 32'd0);
    end

    // full held for 5 cycles while in W1.
    send_desc(vecs[0], 1'b0);
    @(negedge clk);
    chk("bp_w0_wr_en", bus.wr_en, 32'd1);
    @(posedge clk); #1;
    bus.full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_stall_wr_en", bus.wr_en, 32'd0);
      @(posedge clk); #1;
    end
    bus.full = 1'b0;
    wait_idle();
    model_size++;
    check_words("bp", vecs[0]);
    chk("bp_cmd_size", bus.cmd_size, model_size);

    // full toggling every cycle across the burst.
    send_desc(vecs[1], 1'b0);
    for (int k = 0; k < 12; k++) begin
      bus.full = (k % 2 == 0);
      @(posedge clk); #1;
    end
    bus.full = 1'b0;
    wait_idle();
    model_size++;
    check_words("tog", vecs[1]);
    chk("tog_cmd_size", bus.cmd_size, model_size);

    // Reset while in W1.
    send_desc(vecs[2], 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr_en", bus.wr_en, 32'd0);
    chk("mid_rst_cmd_size", bus.cmd_size, 32'd0);
    chk("mid_rst_op_en", bus.op_en, 32'd0);
    chk("mid_rst_err_illegal", bus.err_illegal, 32'd0);
    chk("mid_rst_err_overflow", bus.err_overflow, 32'd0);
    chk("mid_rst_desc_ready", bus.desc_ready, 32'd1);
    wq.delete();
    wr_total = 0;

    // Fill to capacity, then one more.
    for (int i = 0; i < 127; i++) begin
      send_desc(vecs[0], 1'b0);
      wait_idle();
      wq.delete();
    end
    chk("cap_cmd_size", bus.cmd_size, 32'd127);
    chk("cap_writes", wr_total, 32'd381);
    chk("cap_err_overflow", bus.err_overflow, 32'd0);
    send_desc(vecs[1], 1'b0);
    @(negedge clk);
    chk("ovf_wr_en", bus.wr_en, 32'd0);
    repeat (4) @(negedge clk);
    chk("ovf_writes", wr_total, 32'd381);
    chk("ovf_err_overflow", bus.err_overflow, 32'd1);
    chk("ovf_cmd_size", bus.cmd_size, 32'd127);
    chk("ovf_err_illegal", bus.err_illegal, 32'd0);
    chk("ovf_desc_ready", bus.desc_ready, 32'd1);
    wq.delete();

    // go together with a descriptor: descriptor wins, held go then seals.
    do_reset();
    wr_total = 0;
    send_desc(vecs[2], 1'b1);
    @(negedge clk);
    chk("go_desc_op_en", bus.op_en, 32'd0);
    chk("go_desc_wr_en", bus.wr_en, 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (bus.op_en === 1'b1) break;
      @(negedge clk);
    end
    chk("go_op_en", bus.op_en, 32'd1);
    chk("go_desc_ready", bus.desc_ready, 32'd0);
    chk("go_cmd_size", bus.cmd_size, 32'd1);
    check_words("go", vecs[2]);
    @(posedge clk); #1;
    bus.go = 1'b0;
    bus.desc_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("started_desc_ready", bus.desc_ready, 32'd0);
      chk("started_wr_en", bus.wr_en, 32'd0);
    end
    bus.desc_valid = 1'b0;
    chk("started_op_en_sticky", bus.op_en, 32'd1);
    chk("started_writes", wr_total, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
